// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz timing definitions for the horizontal and vertical stages.
// Constants are in 50 MHz clocks (horizontal) or lines (vertical).
package vga_timing_pkg;

  typedef enum logic [1:0] {SYNC, BACK, DISP, FRONT} phase_t;

  localparam int H_SYNC_640      = 192;
  localparam int H_BACK_640      = 96;
  localparam int H_DISP_640      = 1280;
  localparam int H_FRONT_640     = 32;
  localparam int CLK_PER_PIX_640 = 2;

  localparam int V_SYNC_480  = 2;
  localparam int V_BACK_480  = 33;
  localparam int V_DISP_480  = 480;
  localparam int V_FRONT_480 = 10;

  function automatic int h_total(input int sync, input int back, input int disp, input int front);
    return sync + back + disp + front;
  endfunction

endpackage

// File: rtl/vga_htiming_if.sv
// Horizontal timing bundle from the line generator to the vsync and pixel stages.
interface vga_htiming_if;
  logic       VGA_HSYNC;
  logic       DE;
  logic [9:0] HPIXEL;
  logic       PIX_TICK;
  logic       LINE_END;

  modport master (output VGA_HSYNC, output DE, output HPIXEL, output PIX_TICK, output LINE_END);
  modport slave  (input  VGA_HSYNC, input  DE, input  HPIXEL, input  PIX_TICK, input  LINE_END);
endinterface

// File: rtl/vga_htiming.sv
// Horizontal VGA timing: line counter, phase FSM and pixel divider, with every
// output registered from the next-state values so it lines up with the counter.
module vga_htiming
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC      = H_SYNC_640,
  parameter int H_BACK      = H_BACK_640,
  parameter int H_DISP      = H_DISP_640,
  parameter int H_FRONT     = H_FRONT_640,
  parameter int CLK_PER_PIX = CLK_PER_PIX_640
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  vga_htiming_if.master hif
);

  localparam int H_TOTAL = h_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int P_W     = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;

  localparam logic [10:0]    SYNC_LAST = 11'(H_SYNC - 1);
  localparam logic [10:0]    BACK_LAST = 11'(H_SYNC + H_BACK - 1);
  localparam logic [10:0]    DISP_LAST = 11'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [10:0]    LINE_LAST = 11'(H_TOTAL - 1);
  localparam logic [P_W-1:0] P_LAST    = P_W'(CLK_PER_PIX - 1);

  if (H_TOTAL > 2048) begin : g_bad_total
    $error("vga_htiming: H_TOTAL exceeds the 11-bit line counter");
  end
  if (CLK_PER_PIX < 1 || (H_DISP % CLK_PER_PIX) != 0) begin : g_bad_pix
    $error("vga_htiming: H_DISP must be a multiple of CLK_PER_PIX");
  end
  if ((H_DISP / CLK_PER_PIX) > 1024) begin : g_bad_cols
    $error("vga_htiming: pixel column does not fit HPIXEL");
  end

  phase_t         state_q, state_d;
  logic [10:0]    c_q, c_d;
  logic [P_W-1:0] p_q, p_d;
  logic [9:0]     hpix_q, hpix_d;
  logic           hsync_q, hsync_d;
  logic           de_q, de_d;
  logic           tick_q, tick_d;
  logic           le_q, le_d;

  // NOTE: every always_comb output gets a default before any branch, so no latches are inferred.
  always_comb begin
    c_d     = (c_q == LINE_LAST) ? 11'd0 : c_q + 11'd1;
    state_d = state_q;
    unique case (state_q)
      SYNC:  if (c_q == SYNC_LAST) state_d = BACK;
      BACK:  if (c_q == BACK_LAST) state_d = DISP;
      DISP:  if (c_q == DISP_LAST) state_d = FRONT;
      FRONT: if (c_q == LINE_LAST) state_d = SYNC;
    endcase

    // The pixel phase restarts on DISP entry and only runs while staying in DISP.
    p_d = '0;
    if (state_q == DISP && state_d == DISP) begin
      p_d = (p_q == P_LAST) ? '0 : p_q + P_W'(1);
    end

    hpix_d = '0;
    if (state_d == DISP && state_q == DISP) begin
      hpix_d = (p_q == P_LAST) ? hpix_q + 10'd1 : hpix_q;
    end else if (state_d == FRONT) begin
      hpix_d = hpix_q;
    end

    hsync_d = (state_d != SYNC);
    de_d    = (state_d == DISP);
    tick_d  = (state_d == DISP) && (p_d == P_LAST);
    le_d    = (c_d == LINE_LAST);
  end

  // NOTE: state registers use non-blocking assignments so all of them sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SYNC;
      c_q     <= '0;
      p_q     <= '0;
      hpix_q  <= '0;
      hsync_q <= 1'b0;
      de_q    <= 1'b0;
      tick_q  <= 1'b0;
      le_q    <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      c_q     <= c_d;
      p_q     <= p_d;
      hpix_q  <= hpix_d;
      hsync_q <= hsync_d;
      de_q    <= de_d;
      tick_q  <= tick_d;
      le_q    <= le_d;
    end
  end

  assign hif.VGA_HSYNC = hsync_q;
  assign hif.DE        = de_q;
  assign hif.HPIXEL    = hpix_q;
  assign hif.PIX_TICK  = tick_q;
  assign hif.LINE_END  = le_q;

endmodule

// File: tb/tb_vga_htiming.sv
// Bench for vga_htiming: default 640-wide timing and a tiny 16-clock line, both
// checked every clock against a position-based model of the line layout.
module tb_vga_htiming;
  import vga_timing_pkg::*;

  localparam int TB_T = 1600;
  localparam int TS_T = 16;

  typedef struct packed {
    logic       hsync;
    logic       de;
    logic [9:0] hpix;
    logic       tick;
    logic       le;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;

  vga_htiming_if hif_big ();
  vga_htiming_if hif_small ();

  vga_htiming dut_big (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .hif  (hif_big)
  );

  vga_htiming #(
    .H_SYNC(4), .H_BACK(2), .H_DISP(8), .H_FRONT(2), .CLK_PER_PIX(2)
  ) dut_small (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .hif  (hif_small)
  );

  always #10 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  int cb = 0;
  int cs = 0;

  bit stats_on = 0;
  int b_since, b_de, b_tick, b_lines;
  int s_since, s_de, s_tick;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs derived purely from the position within the line.
  function automatic exp_t model(input int c, input int hs, input int hb, input int hd,
                                 input int hf, input int cpp);
    exp_t m;
    int ds, dend, tot;
    ds   = hs + hb;
    dend = ds + hd;
    tot  = dend + hf;
    m.hsync = (c >= hs);
    m.de    = (c >= ds) && (c < dend);
    if (m.de)           m.hpix = 10'((c - ds) / cpp);
    else if (c >= dend) m.hpix = 10'(hd / cpp - 1);
    else                m.hpix = 10'd0;
    m.tick  = m.de && (((c - ds) % cpp) == cpp - 1);
    m.le    = (c == tot - 1);
    return m;
  endfunction

  task automatic compare(input string pfx, input exp_t e, input logic hs, input logic de,
                         input logic [9:0] hp, input logic tk, input logic le);
    check({pfx, "_hsync"}, 32'(hs), 32'(e.hsync));
    check({pfx, "_de"},    32'(de), 32'(e.de));
    check({pfx, "_hpixel"}, 32'(hp), 32'(e.hpix));
    check({pfx, "_pix_tick"}, 32'(tk), 32'(e.tick));
    check({pfx, "_line_end"}, 32'(le), 32'(e.le));
  endtask

  task automatic step(input logic r, input logic e);
    reset = r;
    en    = e;
    @(posedge clk);
    if (!r) begin
      cb = 0;
      cs = 0;
    end else if (e) begin
      cb = (cb + 1) % TB_T;
      cs = (cs + 1) % TS_T;
    end
    #1;
    compare("big", model(cb, H_SYNC_640, H_BACK_640, H_DISP_640, H_FRONT_640, CLK_PER_PIX_640),
            hif_big.VGA_HSYNC, hif_big.DE, hif_big.HPIXEL, hif_big.PIX_TICK, hif_big.LINE_END);
    compare("small", model(cs, 4, 2, 8, 2, 2),
            hif_small.VGA_HSYNC, hif_small.DE, hif_small.HPIXEL, hif_small.PIX_TICK,
            hif_small.LINE_END);
    if (stats_on) begin
      b_since++;
      b_de   += int'(hif_big.DE);
      b_tick += int'(hif_big.PIX_TICK);
      if (hif_big.LINE_END) begin
        check("big_line_period", 32'(b_since), 32'(TB_T));
        check("big_de_clocks",   32'(b_de),    32'(1280));
        check("big_pix_ticks",   32'(b_tick),  32'(640));
        b_lines++;
        b_since = 0; b_de = 0; b_tick = 0;
      end
      s_since++;
      s_de   += int'(hif_small.DE);
      s_tick += int'(hif_small.PIX_TICK);
      if (hif_small.LINE_END) begin
        check("small_line_period", 32'(s_since), 32'(TS_T));
        check("small_de_clocks",   32'(s_de),    32'(8));
        check("small_pix_ticks",   32'(s_tick),  32'(4));
        s_since = 0; s_de = 0; s_tick = 0;
      end
    end
  endtask

  initial begin
    // Reset held for 5 clocks.
    repeat (5) step(1'b0, 1'b1);

    // Three full default lines with per-line statistics.
    b_since = 1; b_de = 0; b_tick = 0; b_lines = 0;
    s_since = 1; s_de = 0; s_tick = 0;
    stats_on = 1;
    repeat (3 * TB_T) step(1'b1, 1'b1);
    stats_on = 0;
    check("big_lines_seen", 32'(b_lines), 32'(3));

    // Freeze mid-line, then freeze on the wrap clock with LINE_END high.
    for (int i = 0; i < TB_T && cb != 700; i++) step(1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b0);
    for (int i = 0; i < TB_T && cb != TB_T - 1; i++) step(1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b0);
    repeat (TB_T + 20) step(1'b1, 1'b1);

    // Abort a line with reset mid-way.
    for (int i = 0; i < TB_T && cb != 1000; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    repeat (TB_T + 20) step(1'b1, 1'b1);

    // Random enable and occasional resets.
    for (int i = 0; i < 6000; i++) begin
      step(logic'($urandom_range(0, 499) != 0), logic'($urandom_range(0, 7) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
